// File: rtl/square_wave_meter_if.sv
// Signal bundle between a square-wave source and the meter.
// master: the meter (takes squareIn, drives the measurement outputs).
// slave : the source/consumer side (drives squareIn, observes the results).
interface square_wave_meter_if;
  logic       squareIn;
  logic [3:0] mOut;
  logic [3:0] nOut;
  logic       measValid;
  logic       ovf;
  logic       stuck;

  modport master (
    input  squareIn,
    output mOut,
    output nOut,
    output measValid,
    output ovf,
    output stuck
  );

  modport slave (
    output squareIn,
    input  mOut,
    input  nOut,
    input  measValid,
    input  ovf,
    input  stuck
  );
endinterface

// File: rtl/square_wave_meter.sv
// Purpose : measure high/low time of squareIn in TICK_CYCLES units, publish {m,n} per period.
// Latency : measValid one cycle after the reporting rise is sampled (+2 with SQW_METER_SYNC_EN).
// Backpress: none; results are a strobe, a consumer that misses measValid still sees held mOut/nOut.
//
// Ports: clk, reset (sync, active-low); mif.master carries squareIn in and
//        mOut/nOut (4-bit units), measValid (1-cycle pulse), ovf (saturated pair), stuck (no edges).
// Build option: define SQW_METER_SYNC_EN to insert a two-flop synchronizer ahead of the sampler.
module square_wave_meter #(
  parameter int TICK_CYCLES   = 10,
  parameter int TIMEOUT_UNITS = 32
) (
  input  logic                clk,
  input  logic                reset,
  square_wave_meter_if.master mif
);

  localparam int UW = $clog2(TIMEOUT_UNITS + 1);
  localparam int PW = $clog2(TICK_CYCLES + 1);

`ifdef SQW_METER_SYNC_EN
  localparam int VD = 4;
`else
  localparam int VD = 2;
`endif

  localparam logic [1:0] WAIT_RISE = 2'd0;
  localparam logic [1:0] MEAS_HIGH = 2'd1;
  localparam logic [1:0] MEAS_LOW  = 2'd2;

  logic          s_in;
  logic          s;
  logic          s_d;
  logic [VD-1:0] smp_vld;
  logic          edges_ok;
  logic          edge_det;
  logic          rise;
  logic          fall;

  logic [1:0]    state;
  logic [PW-1:0] pre;
  logic [UW-1:0] units;
  logic          timeout;

  logic          half_up;
  logic [UW:0]   rnd;
  logic          ph_ovf;
  logic [3:0]    ph_val;

  logic [3:0]    m_hold;
  logic          m_hold_ovf;

`ifdef SQW_METER_SYNC_EN
  logic sync_q1;
  logic sync_q2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= mif.squareIn;
      sync_q2 <= sync_q1;
    end
  end

  assign s_in = sync_q2;
`else
  assign s_in = mif.squareIn;
`endif

  // smp_vld shadows the input pipeline: a stage becomes valid only once it
  // holds a real sample. Without it, the zeros loaded by reset would look
  // like a rise when squareIn is already high, and a partial high phase
  // would be reported as a full one.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s       <= 1'b0;
      s_d     <= 1'b0;
      smp_vld <= '0;
    end else begin
      s       <= s_in;
      s_d     <= s;
      smp_vld <= {smp_vld[VD-2:0], 1'b1};
    end
  end

  assign edges_ok = smp_vld[VD-1];
  assign edge_det = edges_ok & (s ^ s_d);
  assign rise     = edge_det & s;
  assign fall     = edge_det & ~s;

  // units*TICK_CYCLES + pre equals the cycles elapsed since the last edge,
  // counting the edge cycle itself, so on the next edge it is exactly L.
  assign timeout = (units == UW'(TIMEOUT_UNITS)) & ~edge_det;

  // Round half up: add one unit when the remainder is at least half a unit.
  assign half_up = ({pre, 1'b0} >= (PW + 1)'(TICK_CYCLES));
  assign rnd     = {1'b0, units} + {{UW{1'b0}}, half_up};
  assign ph_ovf  = (rnd > (UW + 1)'(15));
  assign ph_val  = ph_ovf ? 4'd15 : rnd[3:0];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= WAIT_RISE;
      pre           <= '0;
      units         <= '0;
      m_hold        <= '0;
      m_hold_ovf    <= 1'b0;
      mif.mOut      <= '0;
      mif.nOut      <= '0;
      mif.measValid <= 1'b0;
      mif.ovf       <= 1'b0;
      mif.stuck     <= 1'b0;
    end else begin
      mif.measValid <= 1'b0;
      if (edge_det) begin
        pre       <= PW'(1);
        units     <= '0;
        mif.stuck <= 1'b0;
        case (state)
          WAIT_RISE: begin
            if (rise) state <= MEAS_HIGH;
          end
          MEAS_HIGH: begin
            if (fall) begin
              m_hold     <= ph_val;
              m_hold_ovf <= ph_ovf;
              state      <= MEAS_LOW;
            end
          end
          MEAS_LOW: begin
            // The reporting rise is also the start of the next high phase.
            if (rise) begin
              mif.mOut      <= m_hold;
              mif.nOut      <= ph_val;
              mif.ovf       <= m_hold_ovf | ph_ovf;
              mif.measValid <= 1'b1;
              state         <= MEAS_HIGH;
            end
          end
          default: state <= WAIT_RISE;
        endcase
      end else if (timeout) begin
        // Counters park at the limit; outputs keep the last published pair.
        mif.stuck <= 1'b1;
        state     <= WAIT_RISE;
      end else if (pre == PW'(TICK_CYCLES - 1)) begin
        pre   <= '0;
        units <= units + UW'(1);
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_square_wave_meter.sv
module tb_square_wave_meter;

  localparam int T    = 10;
  localparam int TO   = 32;
  localparam int TOT  = T * TO;
  localparam int NMAX = 4096;
`ifdef SQW_METER_SYNC_EN
  localparam int SYN = 2;
`else
  localparam int SYN = 0;
`endif

  logic clk;
  logic reset;
  int   cyc = 0;

  square_wave_meter_if mif();

  square_wave_meter #(
    .TICK_CYCLES  (T),
    .TIMEOUT_UNITS(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .mif  (mif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model: events keyed by the cycle in which they become visible.
  bit edge_at [0:NMAX-1];
  bit rst_at  [0:NMAX-1];
  bit rep_at  [0:NMAX-1];
  int rep_m   [0:NMAX-1];
  int rep_n   [0:NMAX-1];
  bit rep_o   [0:NMAX-1];

  // Last two detected edges since reset (index 0 is the older one).
  bit e_pol [0:1];
  int e_t   [0:1];
  int e_cnt = 0;

  bit chk_en = 1'b0;
  int pulses = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic int units_of(input int len);
    return (2 * len + T) / (2 * T);
  endfunction

  // A rise publishes when the two edges before it (since reset) were a rise
  // then a fall, and neither phase outlasted the timeout.
  task automatic note_edge(input bit pol, input int d);
    int uh;
    int ul;
    if (d + 1 < NMAX) begin
      edge_at[d] = 1'b1;
      if (pol && e_cnt >= 2 && e_pol[0] && !e_pol[1] &&
          (e_t[1] - e_t[0]) <= TOT && (d - e_t[1]) <= TOT) begin
        uh = units_of(e_t[1] - e_t[0]);
        ul = units_of(d - e_t[1]);
        rep_at[d+1] = 1'b1;
        rep_m[d+1]  = (uh > 15) ? 15 : uh;
        rep_n[d+1]  = (ul > 15) ? 15 : ul;
        rep_o[d+1]  = (uh > 15) || (ul > 15);
      end
    end
    e_pol[0] = e_pol[1];
    e_t[0]   = e_t[1];
    e_pol[1] = pol;
    e_t[1]   = d;
    if (e_cnt < 2) e_cnt++;
  endtask

  // Called just after a rising clock edge; holds the level for 'cycles' edges.
  task automatic drive(input logic lvl, input int cycles);
    if (lvl !== mif.squareIn) note_edge(lvl, cyc + 1 + SYN);
    mif.squareIn = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    if (cyc + 1 < NMAX) rst_at[cyc+1] = 1'b1;
    e_cnt = 0;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic chk_outputs(input string tag, input int m, input int n, input int o);
    chk({tag, "_mOut"}, int'(mif.mOut), m);
    chk({tag, "_nOut"}, int'(mif.nOut), n);
    chk({tag, "_ovf"},  int'(mif.ovf),  o);
  endtask

  // Per-cycle comparison against the model.
  int cur_m = 0;
  int cur_n = 0;
  int cur_o = 0;
  int last_d = 0;

  always @(negedge clk) begin
    int t;
    int delta;
    int exp_v;
    if (chk_en && cyc < NMAX) begin
      t = cyc;
      if (rst_at[t]) begin
        cur_m  = 0;
        cur_n  = 0;
        cur_o  = 0;
        last_d = t;
      end
      if (edge_at[t]) last_d = t;
      exp_v = rep_at[t] ? 1 : 0;
      if (rep_at[t]) begin
        cur_m = rep_m[t];
        cur_n = rep_n[t];
        cur_o = rep_o[t] ? 1 : 0;
      end
      if (mif.measValid) pulses++;
      chk("measValid", int'(mif.measValid), exp_v);
      chk("mOut", int'(mif.mOut), cur_m);
      chk("nOut", int'(mif.nOut), cur_n);
      chk("ovf",  int'(mif.ovf),  cur_o);
      delta = t - last_d;
      if (delta >= 1 && delta <= TOT - 1)
        chk("stuck", int'(mif.stuck), 0);
      else if (delta >= TOT + 2)
        chk("stuck", int'(mif.stuck), 1);
    end
  end

  initial begin
    int p_save;
    reset        = 1'b0;
    mif.squareIn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_at[cyc] = 1'b1;
    reset       = 1'b1;
    chk_en      = 1'b1;

    // Reset state
    chk_outputs("reset", 0, 0, 0);
    chk("reset_measValid", int'(mif.measValid), 0);
    chk("reset_stuck", int'(mif.stuck), 0);

    // Nominal 30/20: reports at rises 2, 3 and 4
    drive(1'b0, 10);
    repeat (4) begin
      drive(1'b1, 30);
      drive(1'b0, 20);
    end
    chk("nominal_pulses", pulses, 3);
    chk_outputs("nominal", 3, 2, 0);

    // Rounding: 34/15 -> 3/2, 35/14 -> 4/1
    drive(1'b1, 34);
    drive(1'b0, 15);
    drive(1'b1, 6);
    chk_outputs("round_34_15", 3, 2, 0);
    drive(1'b1, 29);
    drive(1'b0, 14);
    drive(1'b1, 6);
    chk_outputs("round_35_14", 4, 1, 0);
    drive(1'b1, 24);
    drive(1'b0, 20);

    // Saturation: 200/20 -> 15/2 with ovf, then a normal period clears ovf
    drive(1'b1, 200);
    drive(1'b0, 20);
    drive(1'b1, 6);
    chk_outputs("sat", 15, 2, 1);
    drive(1'b1, 24);
    drive(1'b0, 20);
    drive(1'b1, 6);
    chk_outputs("after_sat", 3, 2, 0);
    drive(1'b1, 24);

    // Stuck low for 400 cycles after a valid period
    drive(1'b0, 20);
    drive(1'b1, 30);
    p_save = pulses;
    drive(1'b0, 340);
    chk("stuck_set", int'(mif.stuck), 1);
    chk_outputs("stuck_hold", 3, 2, 0);
    chk("stuck_no_pulse", pulses, p_save);
    drive(1'b0, 60);
    drive(1'b1, 6);
    chk("stuck_clear", int'(mif.stuck), 0);
    chk("stuck_first_rise_no_pulse", pulses, p_save);
    drive(1'b1, 24);
    drive(1'b0, 20);
    drive(1'b1, 6);
    chk("stuck_resume_pulse", pulses, p_save + 1);
    chk_outputs("stuck_resume", 3, 2, 0);
    drive(1'b1, 24);

    // Reset 15 cycles into a high phase
    drive(1'b0, 20);
    drive(1'b1, 15);
    pulse_reset();
    chk_outputs("midreset", 0, 0, 0);
    chk("midreset_measValid", int'(mif.measValid), 0);
    chk("midreset_stuck", int'(mif.stuck), 0);
    p_save = pulses;
    drive(1'b1, 14);
    drive(1'b0, 20);
    drive(1'b1, 30);
    drive(1'b0, 20);
    chk("midreset_no_early_pulse", pulses, p_save);
    drive(1'b1, 6);
    chk("midreset_pulse", pulses, p_save + 1);
    chk_outputs("midreset_after", 3, 2, 0);
    drive(1'b1, 24);
    drive(1'b0, 10);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
